// File: rtl/vector_mem_arbiter_pkg.sv
// Shared request/response bundle and field widths
// for the vector load/store memory arbiter.
package vector_mem_arbiter_pkg;

  localparam int CORE_ID_W     = 8;
  localparam int ACCESS_ID_W   = 8;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int NUM_CORES_DEF = 4;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_e;

  typedef struct packed {
    logic                   vld;
    access_e                access;
    logic [CORE_ID_W-1:0]   core_id;
    logic [ACCESS_ID_W-1:0] access_id;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      data;
  } request_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO; head is a registered
// entry, zero when empty.
module mem_req_fifo
  import vector_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  request_t               push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output request_t               head
);

  localparam int AW = $clog2(DEPTH);

  request_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter from per-core load/store units
// into a request FIFO, plus core_id response router.
module vector_mem_arbiter
  import vector_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES    = NUM_CORES_DEF,
  parameter int CORE_ID_BASE = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             core_req [NUM_CORES],
  output logic [NUM_CORES-1:0] core_grant,
  output request_t             core_rsp [NUM_CORES],
  output request_t             mem_req,
  input  logic                 mem_req_ready,
  input  request_t             mem_rsp,
  output logic                 route_err
);

  localparam int PW = (NUM_CORES > 1) ?
                      $clog2(NUM_CORES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic          found;
  int            idx;
  request_t      push_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          pop;
  int            rsp_idx;
  logic          rsp_hit;

  // search order starts at rr_ptr; full blocks even on pop
  always_comb begin
    core_grant = '0;
    found      = 1'b0;
    win        = '0;
    idx        = 0;
    push_data  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (!found && core_req[idx].vld) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    if (!reset || full) found = 1'b0;
    if (found) begin
      core_grant[win] = 1'b1;
      push_data       = core_req[win];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (win == PW'(NUM_CORES-1)) ?
                '0 : win + 1'b1;
    end
  end

  assign pop = mem_req.vld && mem_req_ready;

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (found),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (mem_req)
  );

  always_comb begin
    rsp_idx = int'(mem_rsp.core_id) - CORE_ID_BASE;
    rsp_hit = mem_rsp.vld && (rsp_idx >= 0) &&
              (rsp_idx < NUM_CORES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++)
        core_rsp[i] <= '0;
      route_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++)
        core_rsp[i] <= (rsp_hit && rsp_idx == i) ?
                       mem_rsp : '0;
      if (mem_rsp.vld && !rsp_hit) route_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Scoreboard bench for vector_mem_arbiter: model
// predicts grants, FIFO order and response routing.
module tb_vector_mem_arbiter;
  import vector_mem_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int BASE = 8;
  localparam int DEP  = 4;

  logic           clk = 1'b0;
  logic           reset;
  request_t       core_req [N];
  logic [N-1:0]   core_grant;
  request_t       core_rsp [N];
  request_t       mem_req;
  logic           mem_req_ready;
  request_t       mem_rsp;
  logic           route_err;

  int checks = 0;
  int errors = 0;

  bit           mon_en = 1'b0;
  logic [N-1:0] last_grant = '0;
  bit           cont [N];
  request_t     q [$];
  request_t     exp_r [N];
  int           m_rr = 0;
  bit           m_err = 1'b0;
  int           aid = 0;

  always #5 clk = ~clk;

  vector_mem_arbiter #(
    .NUM_CORES    (N),
    .CORE_ID_BASE (BASE),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_req      (core_req),
    .core_grant    (core_grant),
    .core_rsp      (core_rsp),
    .mem_req       (mem_req),
    .mem_req_ready (mem_req_ready),
    .mem_rsp       (mem_rsp),
    .route_err     (route_err)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic request_t mk(input int c,
                                  input access_e a,
                                  input logic [31:0] ad,
                                  input logic [31:0] d);
    request_t r;
    r.vld       = 1'b1;
    r.access    = a;
    r.core_id   = 8'(BASE + c);
    r.access_id = 8'(aid);
    r.addr      = ad;
    r.data      = d;
    aid++;
    return r;
  endfunction

  // scoreboard / model
  always @(negedge clk) begin
    if (mon_en) begin
      logic [N-1:0] eg;
      request_t     em;
      int           w;
      int           ri;
      bit           done;
      eg = '0;
      w = 0;
      done = 1'b0;
      if (reset && q.size() < DEP) begin
        for (int k = 0; k < N; k++) begin
          int ix;
          ix = (m_rr + k) % N;
          if (!done && core_req[ix].vld) begin
            done = 1'b1;
            w = ix;
            eg[ix] = 1'b1;
          end
        end
      end
      chk("grant", core_grant, eg);
      em = (q.size() > 0) ? q[0] : '0;
      chk("mem_req", mem_req, em);
      for (int i = 0; i < N; i++)
        chk("core_rsp", core_rsp[i], exp_r[i]);
      chk("route_err", route_err, m_err);
      last_grant = core_grant;
      if (!reset) begin
        q.delete();
        m_rr = 0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) exp_r[i] = '0;
      end else begin
        if (q.size() > 0 && mem_req_ready)
          void'(q.pop_front());
        if (done) begin
          q.push_back(core_req[w]);
          m_rr = (w + 1) % N;
        end
        for (int i = 0; i < N; i++) exp_r[i] = '0;
        ri = int'(mem_rsp.core_id) - BASE;
        if (mem_rsp.vld) begin
          if (ri >= 0 && ri < N) exp_r[ri] = mem_rsp;
          else m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    mem_rsp = '0;
    for (int i = 0; i < N; i++) begin
      if (last_grant[i]) begin
        if (cont[i]) core_req[i].addr += 32'd4;
        else core_req[i].vld = 1'b0;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < N; i++) cont[i] = 1'b0;
    mem_req_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp = '0;
    for (int i = 0; i < N; i++) begin
      core_req[i] = '0;
      cont[i] = 1'b0;
      exp_r[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_memreq", mem_req, '0);
    chk("rst_grant", core_grant, '0);
    tick();
    reset = 1'b1;

    // single read from core 0
    tick();
    core_req[0] = mk(0, READ_REQ, 32'h100, 0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t1_grant", core_grant, 4'b0001);
    tick();
    @(negedge clk);
    chk("t1_vld", mem_req.vld, 1'b1);
    chk("t1_addr", mem_req.addr, 32'h100);
    tick();
    @(negedge clk);
    chk("t1_idle", mem_req.vld, 1'b0);

    // cores 0..2 continuous from reset
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_req[i] = mk(i, READ_REQ, 32'h1000 * (i + 1), 0);
      cont[i] = 1'b1;
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t2_rr", core_grant, 4'(1 << (k % 3)));
      tick();
    end
    drain(10);

    // fill to full, then single pop
    mem_req_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      core_req[i] = mk(i, WRITE_REQ, 32'h2000 + i, 32'hA0 + i);
      cont[i] = 1'b1;
    end
    repeat (6) tick();
    @(negedge clk);
    chk("t3_full", core_grant, '0);
    tick();
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t3_nobypass", core_grant, '0);
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("t3_resume", $countones(core_grant), 1);
    drain(14);

    // routed response
    mem_rsp = '{vld:1'b1, access:READ_REQ, core_id:8'd10,
                access_id:8'd5, addr:32'h0, data:32'hDEAD};
    tick();
    @(negedge clk);
    chk("t4_vld", core_rsp[2].vld, 1'b1);
    chk("t4_aid", core_rsp[2].access_id, 8'd5);
    chk("t4_data", core_rsp[2].data, 32'hDEAD);
    chk("t4_other", core_rsp[0], '0);
    tick();
    @(negedge clk);
    chk("t4_pulse", core_rsp[2].vld, 1'b0);

    // out-of-range core_id
    mem_rsp = '{vld:1'b1, access:WRITE_REQ, core_id:8'd3,
                access_id:8'd9, addr:32'h0, data:32'h0};
    tick();
    @(negedge clk);
    chk("t5_err", route_err, 1'b1);
    chk("t5_norsp", core_rsp[0].vld | core_rsp[1].vld |
                    core_rsp[2].vld | core_rsp[3].vld, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_sticky", route_err, 1'b1);

    // reset with queued entries
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      core_req[i] = mk(i, READ_REQ, 32'h300 + i, 0);
    repeat (4) tick();
    core_req[3] = mk(3, READ_REQ, 32'h400, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_nogrant", core_grant, '0);
    tick();
    reset = 1'b1;
    core_req[3].vld = 1'b0;
    @(negedge clk);
    chk("t6_memreq", mem_req, '0);
    chk("t6_err", route_err, 1'b0);
    tick();
    core_req[1] = mk(1, READ_REQ, 32'h500, 0);
    core_req[0] = mk(0, READ_REQ, 32'h504, 0);
    @(negedge clk);
    chk("t6_first", core_grant, 4'b0001);
    drain(8);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      tick();
      mem_req_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (!core_req[i].vld && $urandom_range(0, 2) == 0)
          core_req[i] = mk(i, access_e'($urandom_range(0, 1)),
                           $urandom, $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        mem_rsp.vld       = 1'b1;
        mem_rsp.access    = access_e'($urandom_range(0, 1));
        mem_rsp.core_id   = 8'($urandom_range(BASE - 1, BASE + N));
        mem_rsp.access_id = 8'($urandom);
        mem_rsp.addr      = $urandom;
        mem_rsp.data      = $urandom;
      end
    end
    drain(16);
    @(negedge clk);
    chk("end_empty", mem_req.vld, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_arbiter.md
Name: vector_mem_arbiter

Overview:
Downstream neighbour of the per-core vector load/store units. Collects request_t memory requests from NUM_CORES load/store units, arbitrates round-robin and queues winners in a request FIFO toward the memory port. Routes memory responses back to the issuing unit by core_id. Sits between the load/store units and the shared memory model/controller.

Parameters:
NUM_CORES, 4, number of load/store requesters.
CORE_ID_BASE, 8, core_id of requester 0; requester i carries core_id CORE_ID_BASE+i.
FIFO_DEPTH, 8, request FIFO entries; power of two, >=2.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-low reset.
core_req[NUM_CORES]  input  request_t  per-core request; held until granted.
core_grant  output  NUM_CORES  one-hot acceptance, same cycle as capture.
core_rsp[NUM_CORES]  output  request_t  per-core response, one-cycle vld pulse per response.
mem_req  output  request_t  FIFO head toward memory.
mem_req_ready  input  1  memory accepts mem_req this cycle.
mem_rsp  input  request_t  memory response (vld, core_id, access_id, data).
route_err  output  1  sticky: response with out-of-range core_id seen.

Behaviour:
- One clock; reset is synchronous and active-low: on clk edge with reset==0 all outputs 0, FIFO empty, rr_ptr=0, route_err=0. Reset mid-operation discards queued requests and in-flight routing; no grant while reset low.
- Arbitration (combinational grant from registered state): eligible = core_req[i].vld. If FIFO count<FIFO_DEPTH, grant the first eligible index searching rr_ptr, rr_ptr+1, ... mod NUM_CORES. At most one grant bit per cycle. No grant when full, even if a pop occurs that cycle (no bypass).
- On grant, rr_ptr <= (winner+1) mod NUM_CORES; otherwise rr_ptr holds.
- Granted request pushed unmodified (all fields, core_id/access_id passed through) at that edge.
- mem_req: registered view of FIFO head; mem_req.vld=1 iff FIFO non-empty, else mem_req=0. Latency grant -> mem_req.vld: 1 cycle minimum.
- Pop when mem_req.vld && mem_req_ready; next entry (if any) visible next cycle. Back-to-back pops at 1/cycle.
- Simultaneous push and pop: count unchanged, order preserved. Pointers wrap mod FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Response routing: idx = mem_rsp.core_id - CORE_ID_BASE. If mem_rsp.vld and 0<=idx<NUM_CORES: core_rsp[idx] <= mem_rsp next edge (1-cycle latency); all other core_rsp <= 0. Every core_rsp is cleared each cycle without a matching response (single-cycle pulse).
- Out-of-range idx with vld: response dropped, route_err <= 1 and held until reset.
- Responses for both READ_REQ (data valid) and WRITE_REQ (ack, data don't-care) are routed; no reordering, no response buffering (memory delivers at most one per cycle).
- Request path and response path independent; same-cycle push/pop/response all legal.

Decomposition:
- Shared package: request_t, access type constants READ_REQ/WRITE_REQ, field widths (core_id, access_id, addr, data), NUM_CORES default.
- Sub-module mem_req_fifo: synchronous request_t FIFO (push, pop, full, empty, count, head); arbiter, rr pointer and response router stay in the top.

Test Plan:
- Core 0 alone issues read addr 0x100, mem_req_ready=1 -> core_grant=4'b0001 same cycle; mem_req.vld=1, addr 0x100 next cycle; popped; no further mem_req.vld.
- Cores 0,1,2 hold requests continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles; mem_req order matches grant order.
- FIFO_DEPTH=4, mem_req_ready=0, cores 0-3 requesting -> 4 grants then core_grant=0; raise mem_req_ready one cycle -> one pop, grant resumes the cycle after, never same cycle.
- mem_rsp vld core_id=10, access_id=5, data 0xDEAD -> core_rsp[2] vld with same fields next cycle for exactly one cycle; other core_rsp 0.
- mem_rsp vld core_id=3 (below base) -> no core_rsp, route_err=1 and stays 1 until reset.
- Fill 3 entries, assert reset=0 one edge -> mem_req=0, core_grant=0, route_err=0; new request after reset gets first grant to core 0 search order.
